// File: rtl/adc128s022_emulator.sv
// ============================================================================
// Module  : adc128s022_emulator
// Brief   : SPI-slave model of the ADC128S022 8-channel 12-bit ADC, clocked by clk.
// Revision: 1.0
// ============================================================================
`default_nettype none

module adc128s022_emulator #(
   parameter int         SyncStages   = 2,
   parameter logic [2:0] ResetChannel = 3'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [95:0] ch_data,
   input  logic        adc_cs_n,
   input  logic        adc_sclk,
   input  logic        adc_din,
   output logic        adc_dout,
   output logic [2:0]  conv_addr,
   output logic        frame_done,
   output logic        frame_abort
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_WRAP  = 2'd2;

   logic [SyncStages-1:0] cs_sync_q, sclk_sync_q, din_sync_q;
   logic                  cs_prev_q, sclk_prev_q;

   logic [1:0]  state_q, state_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] shreg_q, shreg_d;
   logic [2:0]  addr_sh_q, addr_sh_d;
   logic [2:0]  next_addr_q, next_addr_d;
   logic [2:0]  conv_addr_q, conv_addr_d;
   logic        done_q, done_d;
   logic        abort_q, abort_d;

   logic        w_cs_s, w_sclk_s, w_din_s;
   logic        w_cs_fall, w_cs_rise, w_sclk_fall, w_sclk_rise;
   logic [4:0]  w_cnt_inc;
   logic [11:0] w_ch [8];

   genvar k;
   generate
      for (k = 0; k < 8; k++) begin : g_ch
         assign w_ch[k] = ch_data[12*k +: 12];
      end
   endgenerate

   // Chains reset to the idle pin levels so releasing reset never fakes an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '1;
         din_sync_q  <= '0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b1;
      end else begin
         cs_sync_q   <= {cs_sync_q[SyncStages-2:0], adc_cs_n};
         sclk_sync_q <= {sclk_sync_q[SyncStages-2:0], adc_sclk};
         din_sync_q  <= {din_sync_q[SyncStages-2:0], adc_din};
         cs_prev_q   <= cs_sync_q[SyncStages-1];
         sclk_prev_q <= sclk_sync_q[SyncStages-1];
      end
   end

   assign w_cs_s      = cs_sync_q[SyncStages-1];
   assign w_sclk_s    = sclk_sync_q[SyncStages-1];
   assign w_din_s     = din_sync_q[SyncStages-1];
   assign w_cs_fall   = cs_prev_q & ~w_cs_s;
   assign w_cs_rise   = ~cs_prev_q & w_cs_s;
   assign w_sclk_fall = sclk_prev_q & ~w_sclk_s;
   assign w_sclk_rise = ~sclk_prev_q & w_sclk_s;
   assign w_cnt_inc   = bit_cnt_q + 5'd1;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      addr_sh_d   = addr_sh_q;
      next_addr_d = next_addr_q;
      conv_addr_d = conv_addr_q;
      done_d      = 1'b0;
      abort_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            shreg_d = '0;
            if (w_cs_fall) begin
               conv_addr_d = next_addr_q;
               shreg_d     = {4'b0000, w_ch[next_addr_q]};
               bit_cnt_d   = '0;
               addr_sh_d   = '0;
               state_d     = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_cs_rise) begin
               shreg_d = '0;
               abort_d = 1'b1;
               state_d = S_IDLE;
            end else if (w_sclk_rise) begin
               bit_cnt_d = w_cnt_inc;
               if (w_cnt_inc >= 5'd3 && w_cnt_inc <= 5'd5)
                  addr_sh_d = {addr_sh_q[1:0], w_din_s};
               if (w_cnt_inc == 5'd16) begin
                  next_addr_d = addr_sh_q;
                  done_d      = 1'b1;
                  state_d     = S_WRAP;
               end
            end else if (w_sclk_fall && bit_cnt_q != 5'd0 && bit_cnt_q <= 5'd15) begin
               shreg_d = {shreg_q[14:0], 1'b0};
            end
         end
         S_WRAP: begin
            if (w_cs_rise) begin
               shreg_d = '0;
               state_d = S_IDLE;
            end else if (w_sclk_fall) begin
               conv_addr_d = next_addr_q;
               shreg_d     = {4'b0000, w_ch[next_addr_q]};
               bit_cnt_d   = '0;
               addr_sh_d   = '0;
               state_d     = S_SHIFT;
            end
         end
         default: begin
            shreg_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         addr_sh_q   <= '0;
         next_addr_q <= ResetChannel;
         conv_addr_q <= ResetChannel;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         addr_sh_q   <= addr_sh_d;
         next_addr_q <= next_addr_d;
         conv_addr_q <= conv_addr_d;
         done_q      <= done_d;
         abort_q     <= abort_d;
      end
   end

   // The shift register MSB is the pin, so reset and idle force dout low together
   assign adc_dout    = shreg_q[15];
   assign conv_addr   = conv_addr_q;
   assign frame_done  = done_q;
   assign frame_abort = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_adc128s022_emulator.sv
// ============================================================================
// Module  : tb_adc128s022_emulator
// Brief   : SPI-master bench for adc128s022_emulator with a frame scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_adc128s022_emulator;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [95:0] ch_data;
   logic        adc_cs_n, adc_sclk, adc_din;
   logic        adc_dout;
   logic [2:0]  conv_addr;
   logic        frame_done, frame_abort;

   adc128s022_emulator #(.SyncStages(2), .ResetChannel(3'd0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ch_data     (ch_data),
      .adc_cs_n    (adc_cs_n),
      .adc_sclk    (adc_sclk),
      .adc_din     (adc_din),
      .adc_dout    (adc_dout),
      .conv_addr   (conv_addr),
      .frame_done  (frame_done),
      .frame_abort (frame_abort)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int abort_cnt = 0;

   always @(posedge clk) begin
      if (frame_done)  done_cnt  <= done_cnt + 1;
      if (frame_abort) abort_cnt <= abort_cnt + 1;
   end

   typedef struct {
      logic [15:0] word;
      logic [2:0]  addr;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] m_next;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One master frame; stop_rise>0 cuts it after that rise (cs raise, or reset if do_reset)
   task automatic spi_frame(input logic [2:0] addr, input bit first, input bit last,
                            input int stop_rise, input bit do_reset,
                            input int mod_fall, input logic [11:0] mod_val);
      logic [15:0] word;
      logic [2:0]  seen_addr;
      int          d0, a0;
      exp_t        e;
      word      = '0;
      seen_addr = '0;
      d0 = done_cnt;
      a0 = abort_cnt;
      if (stop_rise == 0) begin
         e.word = {4'b0000, ch_data[12*m_next +: 12]};
         e.addr = m_next;
         sb.push_back(e);
      end
      if (first) begin
         adc_cs_n = 1'b0;
         wait_clk(HALF);
      end
      for (int i = 1; i <= 16; i++) begin
         adc_sclk = 1'b0;
         adc_din  = (i == 3) ? addr[2] : (i == 4) ? addr[1] : (i == 5) ? addr[0] : 1'b0;
         wait_clk(HALF);
         if (i == mod_fall) ch_data[12*m_next +: 12] = mod_val;
         word     = {word[14:0], adc_dout};
         adc_sclk = 1'b1;
         wait_clk(HALF);
         if (i == 2) seen_addr = conv_addr;
         if (i == stop_rise) begin
            if (do_reset) begin
               rst_n = 1'b0;
               #1;
               check_eq("dout_in_reset", {31'd0, adc_dout}, 32'd0);
               wait_clk(3);
               rst_n  = 1'b1;
               m_next = 3'd0;
               wait_clk(HALF);
               check_eq("reset_no_done", done_cnt - d0, 32'd0);
               check_eq("reset_no_abort", abort_cnt - a0, 32'd0);
            end else begin
               adc_cs_n = 1'b1;
               wait_clk(2 * HALF);
               check_eq("abort_pulse", abort_cnt - a0, 32'd1);
               check_eq("abort_no_done", done_cnt - d0, 32'd0);
               check_eq("abort_dout", {31'd0, adc_dout}, 32'd0);
            end
            return;
         end
      end
      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_eq("frame_word", {16'd0, word}, {16'd0, e.word});
         check_eq("conv_addr", {29'd0, seen_addr}, {29'd0, e.addr});
      end
      check_eq("frame_done_cnt", done_cnt - d0, 32'd1);
      m_next = addr;
      if (last) begin
         adc_cs_n = 1'b1;
         wait_clk(2 * HALF);
         check_eq("end_no_abort", abort_cnt - a0, 32'd0);
         check_eq("idle_dout", {31'd0, adc_dout}, 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d_start;
      rst_n    = 1'b0;
      adc_cs_n = 1'b1;
      adc_sclk = 1'b1;
      adc_din  = 1'b0;
      ch_data  = '0;
      for (int c = 0; c < 8; c++) ch_data[12*c +: 12] = 12'h100 + 12'(c * 12'h11);
      ch_data[0 +: 12]  = 12'h5AF;
      ch_data[60 +: 12] = 12'hFFF;
      m_next = 3'd0;
      wait_clk(3);
      check_eq("rst_dout", {31'd0, adc_dout}, 32'd0);
      check_eq("rst_conv_addr", {29'd0, conv_addr}, 32'd0);
      check_eq("rst_done", {31'd0, frame_done}, 32'd0);
      check_eq("rst_abort", {31'd0, frame_abort}, 32'd0);
      rst_n = 1'b1;
      wait_clk(5);

      // basic frame, then address 5 selects the following frame
      spi_frame(3'd0, 1, 1, 0, 0, 0, 12'h0);
      spi_frame(3'd5, 1, 1, 0, 0, 0, 12'h0);
      spi_frame(3'd0, 1, 1, 0, 0, 0, 12'h0);

      // back-to-back frames with cs held low
      ch_data[60 +: 12] = 12'hFC0;
      ch_data[12 +: 12] = 12'hF00;
      ch_data[24 +: 12] = 12'hC00;
      ch_data[36 +: 12] = 12'hA55;
      ch_data[48 +: 12] = 12'h3C3;
      d_start = done_cnt;
      spi_frame(3'd5, 1, 0, 0, 0, 0, 12'h0);
      spi_frame(3'd1, 0, 0, 0, 0, 0, 12'h0);
      spi_frame(3'd2, 0, 0, 0, 0, 0, 12'h0);
      spi_frame(3'd3, 0, 0, 0, 0, 0, 12'h0);
      spi_frame(3'd4, 0, 1, 0, 0, 0, 12'h0);
      check_eq("b2b_done_total", done_cnt - d_start, 32'd5);

      // abort after rise 8 while sending addr 6
      spi_frame(3'd6, 1, 0, 8, 0, 0, 12'h0);
      spi_frame(3'd7, 1, 1, 0, 0, 0, 12'h0);

      // reset mid-frame, cs stays low across release
      spi_frame(3'd3, 1, 0, 8, 1, 0, 12'h0);
      spi_frame(3'd2, 1, 1, 0, 0, 0, 12'h0);

      // ch_data change mid-frame only shows up in the next frame
      spi_frame(3'd2, 1, 1, 0, 0, 6, 12'h123);
      spi_frame(3'd2, 1, 1, 0, 0, 0, 12'h0);

      check_eq("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
